// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants and state encoding for the 4-requester round-robin mux arbiter.
package mux4_arb_pkg;
   localparam int NUM_REQ = 4;
   localparam int SEL_W   = 2;
   localparam int CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_GAP   = 2'd2
   } arb_state_t;
endpackage

// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between requesters/data sources and the arbiter: requests and mux inputs in, grant/select/output back.
interface mux4_rr_arbiter_if;
   import mux4_arb_pkg::*;

   logic [NUM_REQ-1:0] REQ;
   logic               IN0;
   logic               IN1;
   logic               IN2;
   logic               IN3;
   logic [NUM_REQ-1:0] GNT;
   logic [SEL_W-1:0]   S;
   logic               MO;
   logic               MOV;

   modport master (
      output REQ, IN0, IN1, IN2, IN3,
      input  GNT, S, MO, MOV
   );

   modport slave (
      input  REQ, IN0, IN1, IN2, IN3,
      output GNT, S, MO, MOV
   );
endinterface

// File: rtl/mux4_rr_arbiter_pick.sv
// Combinational 4-way round-robin pick: first set request at or after ptr (mod 4).
// Zero latency; no handshake, the caller decides when the result is used.
module rr_pick4
   import mux4_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [SEL_W-1:0]   ptr,
   output logic [SEL_W-1:0]   winner,
   output logic               any
);

   // Walk from the farthest offset down so the nearest set request overwrites.
   always_comb begin
      winner = ptr;
      any    = |req;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[ptr + SEL_W'(k)]) begin
            winner = ptr + SEL_W'(k);
         end
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of the shared 4:1 mux: one-hot GNT/S one cycle after the pick, MO/MOV one cycle later.
// Owner holds at most HOLD_MAX cycles while others wait; each release costs a GAP plus an IDLE cycle.
module mux4_rr_arbiter
   import mux4_arb_pkg::*;
#(
   parameter int HOLD_MAX = 8
) (
   input  logic CLK,
   input  logic RST,
   mux4_rr_arbiter_if.slave bus
);

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   arb_state_t         state_q, state_d;
   logic [SEL_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [SEL_W-1:0]   sel_q, sel_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic               mo_q, mov_q;

   logic [SEL_W-1:0]   winner;
   logic               any_req;
   logic [NUM_REQ-1:0] owner_mask;
   logic               others_wait;
   logic               at_last;
   logic               mux_out;

   rr_pick4 u_pick (
      .req    (bus.REQ),
      .ptr    (ptr_q),
      .winner (winner),
      .any    (any_req)
   );

   assign owner_mask  = NUM_REQ'(1) << sel_q;
   assign others_wait = |(bus.REQ & ~owner_mask);
   assign at_last     = (cnt_q == HOLD_LAST);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      case (state_q)
         ST_IDLE: begin
            gnt_d = '0;
            if (any_req) begin
               sel_d   = winner;
               gnt_d   = NUM_REQ'(1) << winner;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!bus.REQ[sel_q] || (at_last && others_wait)) begin
               gnt_d   = '0;
               ptr_d   = sel_q + SEL_W'(1);
               state_d = ST_GAP;
            end else begin
               // Lone requester: the counter wraps and the grant simply continues.
               cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
            end
         end
         ST_GAP: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: begin
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      mux_out = 1'b0;
      case (sel_q)
         2'd0: mux_out = bus.IN0;
         2'd1: mux_out = bus.IN1;
         2'd2: mux_out = bus.IN2;
         2'd3: mux_out = bus.IN3;
         default: mux_out = 1'b0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         mo_q    <= 1'b0;
         mov_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         mo_q    <= (state_q == ST_GRANT) ? mux_out : 1'b0;
         mov_q   <= (state_q == ST_GRANT);
      end
   end

   assign bus.GNT = gnt_q;
   assign bus.S   = sel_q;
   assign bus.MO  = mo_q;
   assign bus.MOV = mov_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter with HOLD_MAX=4; outputs sampled 1ns after each rising edge.
module tb_mux4_rr_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   mux4_rr_arbiter_if bus ();

   mux4_rr_arbiter #(.HOLD_MAX(4)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.REQ = 4'b0000;
      step();
      rst     = 1'b0;
   endtask

   task automatic test_reset();
      rst     = 1'b1;
      bus.REQ = 4'b0000;
      bus.IN0 = 1'b0;
      bus.IN1 = 1'b0;
      bus.IN2 = 1'b0;
      bus.IN3 = 1'b0;
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         step();
         total++;
         if ({bus.GNT, bus.S, bus.MO, bus.MOV} !== 8'h00) begin
            bad++;
            $display("FAIL reset_idle cyc=%0d got gnt=%b s=%b mo=%b mov=%b want all zero",
                     c, bus.GNT, bus.S, bus.MO, bus.MOV);
         end
      end
   endtask

   task automatic test_single();
      logic exp_mo;
      logic exp_mov;
      do_reset();
      bus.REQ = 4'b0100;
      for (int k = 1; k <= 12; k++) begin
         bus.IN2 = k[0];
         step();
         exp_mov = (k >= 2);
         exp_mo  = exp_mov ? k[0] : 1'b0;
         total++;
         if (bus.GNT !== 4'b0100 || bus.S !== 2'd2 || bus.MO !== exp_mo || bus.MOV !== exp_mov) begin
            bad++;
            $display("FAIL single k=%0d got gnt=%b s=%0d mo=%b mov=%b want gnt=0100 s=2 mo=%b mov=%b",
                     k, bus.GNT, bus.S, bus.MO, bus.MOV, exp_mo, exp_mov);
         end
      end
      bus.REQ = 4'b0000;
      step();
      total++;
      if (bus.GNT !== 4'b0000 || bus.MOV !== 1'b1) begin
         bad++;
         $display("FAIL single_release got gnt=%b mov=%b want gnt=0000 mov=1", bus.GNT, bus.MOV);
      end
      step();
      total++;
      if (bus.GNT !== 4'b0000 || bus.MOV !== 1'b0 || bus.S !== 2'd2) begin
         bad++;
         $display("FAIL single_gap got gnt=%b mov=%b s=%0d want gnt=0000 mov=0 s=2",
                  bus.GNT, bus.MOV, bus.S);
      end
   endtask

   task automatic test_round_robin();
      logic [3:0] inv;
      logic [3:0] exp_gnt;
      logic [1:0] exp_s;
      logic       exp_mov;
      logic       exp_mo;
      int         r;
      int         own;
      do_reset();
      inv     = 4'b1101;
      bus.IN0 = inv[0];
      bus.IN1 = inv[1];
      bus.IN2 = inv[2];
      bus.IN3 = inv[3];
      bus.REQ = 4'b1111;
      // Each owner: 4 grant cycles then GAP and IDLE, so a 6-cycle period.
      for (int e = 1; e <= 30; e++) begin
         step();
         r       = (e - 1) % 6;
         own     = ((e - 1) / 6) % 4;
         exp_gnt = (r < 4) ? 4'(1 << own) : 4'b0000;
         exp_s   = 2'(own);
         exp_mov = (r >= 1 && r <= 4);
         exp_mo  = exp_mov ? inv[own] : 1'b0;
         total++;
         if (bus.GNT !== exp_gnt || bus.S !== exp_s || bus.MOV !== exp_mov || bus.MO !== exp_mo) begin
            bad++;
            $display("FAIL round_robin e=%0d got gnt=%b s=%0d mo=%b mov=%b want gnt=%b s=%0d mo=%b mov=%b",
                     e, bus.GNT, bus.S, bus.MO, bus.MOV, exp_gnt, exp_s, exp_mo, exp_mov);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset();
      bus.REQ = 4'b1000;
      step();
      total++;
      if (bus.GNT !== 4'b1000 || bus.S !== 2'd3) begin
         bad++;
         $display("FAIL wrap_first got gnt=%b s=%0d want gnt=1000 s=3", bus.GNT, bus.S);
      end
      step();
      bus.REQ = 4'b0000;
      step();
      bus.REQ = 4'b1010;
      step();
      step();
      total++;
      if (bus.GNT !== 4'b0010 || bus.S !== 2'd1) begin
         bad++;
         $display("FAIL wrap_next got gnt=%b s=%0d want gnt=0010 s=1", bus.GNT, bus.S);
      end
      step();
      step();
      step();
      total++;
      if (bus.GNT !== 4'b0010) begin
         bad++;
         $display("FAIL wrap_hold got gnt=%b want 0010", bus.GNT);
      end
      step();
      total++;
      if (bus.GNT !== 4'b0000) begin
         bad++;
         $display("FAIL wrap_forced got gnt=%b want 0000", bus.GNT);
      end
      step();
      step();
      total++;
      if (bus.GNT !== 4'b1000 || bus.S !== 2'd3) begin
         bad++;
         $display("FAIL wrap_third got gnt=%b s=%0d want gnt=1000 s=3", bus.GNT, bus.S);
      end
   endtask

   task automatic test_release();
      int movcnt;
      do_reset();
      bus.IN0 = 1'b1;
      bus.IN1 = 1'b0;
      bus.REQ = 4'b0011;
      movcnt  = 0;
      step();
      movcnt += int'(bus.MOV);
      total++;
      if (bus.GNT !== 4'b0001 || bus.S !== 2'd0) begin
         bad++;
         $display("FAIL release_grant0 got gnt=%b s=%0d want gnt=0001 s=0", bus.GNT, bus.S);
      end
      step();
      movcnt += int'(bus.MOV);
      total++;
      if (bus.MO !== 1'b1 || bus.MOV !== 1'b1) begin
         bad++;
         $display("FAIL release_data got mo=%b mov=%b want mo=1 mov=1", bus.MO, bus.MOV);
      end
      bus.REQ = 4'b0010;
      step();
      movcnt += int'(bus.MOV);
      total++;
      if (bus.GNT !== 4'b0000 || bus.MO !== 1'b1) begin
         bad++;
         $display("FAIL release_gap got gnt=%b mo=%b want gnt=0000 mo=1", bus.GNT, bus.MO);
      end
      step();
      movcnt += int'(bus.MOV);
      total++;
      if (bus.GNT !== 4'b0000) begin
         bad++;
         $display("FAIL release_idle got gnt=%b want 0000", bus.GNT);
      end
      step();
      movcnt += int'(bus.MOV);
      total++;
      if (bus.GNT !== 4'b0010 || bus.S !== 2'd1) begin
         bad++;
         $display("FAIL release_grant1 got gnt=%b s=%0d want gnt=0010 s=1", bus.GNT, bus.S);
      end
      total++;
      if (movcnt != 2) begin
         bad++;
         $display("FAIL release_movcount got %0d want 2", movcnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      // One grant/release of index 2 leaves the pointer at 3.
      bus.REQ = 4'b0100;
      step();
      bus.REQ = 4'b0000;
      step();
      step();
      bus.REQ = 4'b0100;
      step();
      total++;
      if (bus.GNT !== 4'b0100 || bus.S !== 2'd2) begin
         bad++;
         $display("FAIL rstmid_grant got gnt=%b s=%0d want gnt=0100 s=2", bus.GNT, bus.S);
      end
      step();
      rst     = 1'b1;
      bus.REQ = 4'b1100;
      step();
      total++;
      if ({bus.GNT, bus.S, bus.MO, bus.MOV} !== 8'h00) begin
         bad++;
         $display("FAIL rstmid_clear got gnt=%b s=%0d mo=%b mov=%b want all zero",
                  bus.GNT, bus.S, bus.MO, bus.MOV);
      end
      rst = 1'b0;
      step();
      total++;
      if (bus.GNT !== 4'b0100 || bus.S !== 2'd2) begin
         bad++;
         $display("FAIL rstmid_after got gnt=%b s=%0d want gnt=0100 s=2", bus.GNT, bus.S);
      end
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      rst     = 1'b1;
      bus.REQ = 4'b0000;
      bus.IN0 = 1'b0;
      bus.IN1 = 1'b0;
      bus.IN2 = 1'b0;
      bus.IN3 = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_wrap();
      test_release();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

Round-robin arbiter that shares the 4:1 single-bit mux datapath between four requesters. It owns the 2-bit select `S` and issues a one-hot grant. It enforces a bounded hold time per grant and registers the selected input onto `MO`. It sits in front of the mux datapath and replaces the free-running select with a sequenced, fair owner.

## Interface
Parameters:
- `HOLD_MAX`, default 8: maximum consecutive GRANT cycles before forced rotation when another requester is waiting. Legal range 1..255.

Ports:
- `CLK`  input  1  clock. All state changes on the rising edge.
- `RST`  input  1  reset, synchronous, active-high.
- `REQ`  input  4  request; `REQ[i]` = requester i wants the mux.
- `IN0`..`IN3`  input  1 each  data inputs of the shared mux.
- `GNT`  output  4  one-hot grant, registered. All zero when nobody owns the mux.
- `S`  output  2  select, registered; index of the current or most recent owner.
- `MO`  output  1  registered mux output.
- `MOV`  output  1  `MO` valid qualifier.

## Operation
- States: IDLE, GRANT, GAP. The 2-bit `PTR` holds the round-robin start index; the 8-bit `CNT` is the hold counter.
- Pick rule: search indices `PTR`, `PTR+1`, `PTR+2`, `PTR+3` (mod 4). The first set `REQ` bit wins.
- IDLE:
  - If `REQ != 0`: load `S` with the winner, set `GNT = 1<<winner`, set `CNT = 0`, go to GRANT.
  - Else stay in IDLE with `GNT = 0`.
- GRANT, release when either condition holds:
  - `REQ[S] == 0`.
  - `CNT == HOLD_MAX-1` and some `REQ[j]` with `j != S` is set.
- GRANT on release: `GNT <= 0`, `PTR <= S+1` (mod 4, 3 wraps to 0), go to GAP.
- GRANT otherwise: stay in GRANT.
  - `CNT` increments.
  - If `CNT == HOLD_MAX-1` and no other requester is waiting, `CNT` wraps to 0 and the grant continues.
- GAP: exactly one dead cycle with `GNT = 0`, then go to IDLE. No arbitration happens in GAP. `S` holds its value.
- Datapath, every edge:
  - `MO <= (state==GRANT) ? IN[S] : 0`.
  - `MOV <= (state==GRANT)`.
- `S` changes only on the IDLE→GRANT transition.
- `GNT` is always zero or one-hot.
- Reset values: state IDLE, `PTR = 0`, `CNT = 0`, `S = 2'b00`, `GNT = 4'b0000`, `MO = 0`, `MOV = 0`.
- `RST` asserted in any state, including mid-grant, forces the reset values at that edge. The in-flight grant is dropped without a GAP cycle.

## Timing
- `REQ` rises in IDLE at edge t: `GNT`/`S` valid after edge t+1; first valid `MO`/`MOV` after edge t+2.
- Owner drops `REQ` sampled at edge t:
  - `GNT` = 0 after edge t+1 (GAP).
  - IDLE after t+2.
  - Next `GNT` after t+3 at the earliest.
  - Minimum turnaround between owners is 2 zero-grant cycles: GAP plus IDLE.
- `MOV` deasserts one cycle after `GNT` deasserts.
- Forced rotation: with a competitor waiting, one owner holds `GNT` for at most `HOLD_MAX` cycles.
- Simultaneous requests: resolved purely by `PTR` order.
- A requester that rises during GRANT or GAP waits for IDLE.
- With `HOLD_MAX=1` and multiple requesters, each grant lasts exactly 1 cycle.

## Structure
- Package `mux4_arb_pkg` contains:
  - `NUM_REQ = 4` and `SEL_W = 2`.
  - The state enum (IDLE/GRANT/GAP).
  - The hold counter width `CNT_W = 8`.
- Sub-module `rr_pick4`: combinational. Inputs `REQ[3:0]` and `PTR[1:0]`; outputs winner index and `any` flag. It is reused by later arbiters.
- The 4:1 mux is inlined as a case on `S`. Its behaviour is identical to the existing mux datapath: `S=00→IN0`, `01→IN1`, `10→IN2`, `11→IN3`.
- The verification miter instantiates the existing mux datapath on `S` and asserts its output equals `MO` one cycle later while `MOV=1`.

## Test plan
- Reset then idle: `RST=1` for 2 cycles, `REQ=0` → `GNT=0000`, `S=00`, `MO=0`, `MOV=0` held for 10 cycles.
- Single requester: `REQ=0100`, `IN2` toggling 1/0 → `GNT=0100` and `S=10` from cycle 1; `MO` follows `IN2` delayed one cycle with `MOV=1`; grant never released while `REQ[2]=1`, because `CNT` wraps.
- Round-robin, all requesting: `REQ=1111`, `HOLD_MAX=4` → grant order 0,1,2,3,0, each lasting 4 cycles with 2 zero-grant cycles between.
- Wrap-around: grant index 3 completes → `PTR=0`; with `REQ=1010` next grant is 1, then 3.
- Voluntary release: owner 0 drops `REQ` after 2 cycles, `REQ[1]=1` → GAP then IDLE, then `GNT=0010`, `S=01`; `MOV` shows exactly 2 valid cycles for owner 0.
- Reset mid-grant: `RST` during GRANT of index 2 → next cycle `GNT=0000`, `S=00`, `PTR=0`, `MOV=0`; a pending `REQ=1100` after reset grants index 2 first (search order from `PTR=0`).
